// File: rtl/idma_cfg_sequencer.sv
// idma_cfg_sequencer
// Turns one 3D transfer descriptor into the register write/read sequence that
// programs and launches an iDMA channel through its frontend register port.
// It returns the transfer ID read back at launch. Optionally it polls DONE_ID
// until the transfer has completed before it responds.
// The frontend request/response structs are carried as flat fields. Each field
// maps one-to-one onto idma_fe_reg_req_t (addr, write, wdata, wstrb, valid) and
// idma_fe_reg_rsp_t (rdata, error, ready).
module idma_cfg_sequencer #(
    parameter int unsigned NumDims   = 3,
    parameter int unsigned PollGap   = 4,
    parameter logic [31:0] OffConf   = 32'h00,
    parameter logic [31:0] OffDst    = 32'h0C,
    parameter logic [31:0] OffSrc    = 32'h10,
    parameter logic [31:0] OffLen    = 32'h14,
    parameter logic [31:0] OffDstS2  = 32'h18,
    parameter logic [31:0] OffSrcS2  = 32'h1C,
    parameter logic [31:0] OffReps2  = 32'h20,
    parameter logic [31:0] OffDstS3  = 32'h24,
    parameter logic [31:0] OffSrcS3  = 32'h28,
    parameter logic [31:0] OffReps3  = 32'h2C,
    parameter logic [31:0] OffNextId = 32'h44,
    parameter logic [31:0] OffDoneId = 32'h48
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic [31:0] desc_conf_i,
    input  logic [31:0] desc_src_i,
    input  logic [31:0] desc_dst_i,
    input  logic [31:0] desc_len_i,
    input  logic [31:0] desc_src_s2_i,
    input  logic [31:0] desc_dst_s2_i,
    input  logic [31:0] desc_reps2_i,
    input  logic [31:0] desc_src_s3_i,
    input  logic [31:0] desc_dst_s3_i,
    input  logic [31:0] desc_reps3_i,
    input  logic        desc_wait_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_id_o,
    output logic        rsp_err_o,
    output logic [31:0] cfg_req_addr_o,
    output logic        cfg_req_write_o,
    output logic [31:0] cfg_req_wdata_o,
    output logic [3:0]  cfg_req_wstrb_o,
    output logic        cfg_req_valid_o,
    input  logic [31:0] cfg_rsp_rdata_i,
    input  logic        cfg_rsp_error_i,
    input  logic        cfg_rsp_ready_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, WRITE, LAUNCH, GAP, POLL, RESP} state_e;

    // Index of the final write: 4, 7 or 10 writes depending on dimensions.
    localparam logic [3:0] LastWrite = (NumDims >= 3) ? 4'd9 :
                                       (NumDims == 2) ? 4'd6 : 4'd3;
    // Gap counter counts down to zero, so PollGap idle cycles need PollGap-1.
    localparam logic [7:0] GapInit = (PollGap == 0) ? 8'd0 : 8'(PollGap - 1);

    state_e      state_q;
    logic [3:0]  k_q;
    logic [7:0]  gap_cnt_q;
    logic        clear_pend_q;

    logic [31:0] conf_q, src_q, dst_q, len_q;
    logic [31:0] src_s2_q, dst_s2_q, reps2_q;
    logic [31:0] src_s3_q, dst_s3_q, reps3_q;
    logic        desc_wait_q;
    logic [31:0] id_q;

    logic        accept;
    logic        acc_done;
    logic        in_access;
    logic        to_idle;
    logic        err_hit;
    logic        poll_done;
    logic [31:0] poll_diff;
    logic [3:0]  k_next;
    logic [31:0] next_addr;
    logic [31:0] next_wdata;

    assign busy_o    = (state_q != IDLE);
    assign accept    = (state_q == IDLE) & desc_valid_i & desc_ready_o & ~clear_i;
    assign acc_done  = cfg_req_valid_o & cfg_rsp_ready_i;
    assign in_access = (state_q == WRITE) | (state_q == LAUNCH) | (state_q == POLL);
    // An abort during a live access waits for that access to finish; elsewhere it is immediate.
    assign to_idle   = in_access ? (acc_done & (clear_i | clear_pend_q))
                                 : (((state_q != IDLE) | clear_i) & clear_i) |
                                   ((state_q == RESP) & rsp_ready_i);
    assign err_hit   = in_access & acc_done & cfg_rsp_error_i;
    // Wrap-safe "DONE_ID has reached our ID" test.
    assign poll_diff = cfg_rsp_rdata_i - id_q;
    assign poll_done = ~poll_diff[31];
    assign k_next    = k_q + 4'd1;

    // Address/data of the write that follows the current one in the fixed programming order.
    always_comb begin
        next_addr  = OffConf;
        next_wdata = conf_q;
        case (k_next)
            4'd1: begin next_addr = OffDst;   next_wdata = dst_q;    end
            4'd2: begin next_addr = OffSrc;   next_wdata = src_q;    end
            4'd3: begin next_addr = OffLen;   next_wdata = len_q;    end
            4'd4: begin next_addr = OffDstS2; next_wdata = dst_s2_q; end
            4'd5: begin next_addr = OffSrcS2; next_wdata = src_s2_q; end
            4'd6: begin next_addr = OffReps2; next_wdata = reps2_q;  end
            4'd7: begin next_addr = OffDstS3; next_wdata = dst_s3_q; end
            4'd8: begin next_addr = OffSrcS3; next_wdata = src_s3_q; end
            4'd9: begin next_addr = OffReps3; next_wdata = reps3_q;  end
            default: begin next_addr = OffConf; next_wdata = conf_q; end
        endcase
    end

    // Descriptor capture on acceptance and launch ID capture; data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            conf_q      <= desc_conf_i;
            src_q       <= desc_src_i;
            dst_q       <= desc_dst_i;
            len_q       <= desc_len_i;
            src_s2_q    <= desc_src_s2_i;
            dst_s2_q    <= desc_dst_s2_i;
            reps2_q     <= desc_reps2_i;
            src_s3_q    <= desc_src_s3_i;
            dst_s3_q    <= desc_dst_s3_i;
            reps3_q     <= desc_reps3_i;
            desc_wait_q <= desc_wait_i;
        end
        if ((state_q == LAUNCH) && acc_done) begin
            id_q <= cfg_rsp_rdata_i;
        end
    end

    // Sequencer FSM with registered handshake and register-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            k_q             <= '0;
            gap_cnt_q       <= '0;
            clear_pend_q    <= 1'b0;
            desc_ready_o    <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_id_o        <= '0;
            rsp_err_o       <= 1'b0;
            cfg_req_valid_o <= 1'b0;
            cfg_req_write_o <= 1'b0;
            cfg_req_addr_o  <= '0;
            cfg_req_wdata_o <= '0;
            cfg_req_wstrb_o <= '0;
        end else begin
            if (clear_i && cfg_req_valid_o && !acc_done) begin
                clear_pend_q <= 1'b1;
            end
            if (to_idle) begin
                state_q         <= IDLE;
                clear_pend_q    <= 1'b0;
                desc_ready_o    <= 1'b1;
                rsp_valid_o     <= 1'b0;
                cfg_req_valid_o <= 1'b0;
                cfg_req_write_o <= 1'b0;
                cfg_req_addr_o  <= '0;
                cfg_req_wdata_o <= '0;
                cfg_req_wstrb_o <= '0;
            end else if (err_hit) begin
                state_q         <= RESP;
                rsp_valid_o     <= 1'b1;
                rsp_err_o       <= 1'b1;
                rsp_id_o        <= '0;
                cfg_req_valid_o <= 1'b0;
                cfg_req_write_o <= 1'b0;
                cfg_req_addr_o  <= '0;
                cfg_req_wdata_o <= '0;
                cfg_req_wstrb_o <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q         <= WRITE;
                            k_q             <= '0;
                            desc_ready_o    <= 1'b0;
                            clear_pend_q    <= 1'b0;
                            cfg_req_valid_o <= 1'b1;
                            cfg_req_write_o <= 1'b1;
                            cfg_req_addr_o  <= OffConf;
                            cfg_req_wdata_o <= desc_conf_i;
                            cfg_req_wstrb_o <= 4'hF;
                        end else begin
                            desc_ready_o <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (acc_done) begin
                            if (k_q == LastWrite) begin
                                state_q         <= LAUNCH;
                                cfg_req_write_o <= 1'b0;
                                cfg_req_addr_o  <= OffNextId;
                                cfg_req_wdata_o <= '0;
                                cfg_req_wstrb_o <= 4'h0;
                            end else begin
                                k_q             <= k_next;
                                cfg_req_addr_o  <= next_addr;
                                cfg_req_wdata_o <= next_wdata;
                            end
                        end
                    end
                    LAUNCH: begin
                        if (acc_done) begin
                            if (!desc_wait_q) begin
                                state_q         <= RESP;
                                cfg_req_valid_o <= 1'b0;
                                cfg_req_addr_o  <= '0;
                                rsp_valid_o     <= 1'b1;
                                rsp_id_o        <= cfg_rsp_rdata_i;
                                rsp_err_o       <= 1'b0;
                            end else if (PollGap == 0) begin
                                state_q         <= POLL;
                                cfg_req_addr_o  <= OffDoneId;
                            end else begin
                                state_q         <= GAP;
                                gap_cnt_q       <= GapInit;
                                cfg_req_valid_o <= 1'b0;
                                cfg_req_addr_o  <= '0;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q == 8'd0) begin
                            state_q         <= POLL;
                            cfg_req_valid_o <= 1'b1;
                            cfg_req_write_o <= 1'b0;
                            cfg_req_addr_o  <= OffDoneId;
                            cfg_req_wdata_o <= '0;
                            cfg_req_wstrb_o <= 4'h0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 8'd1;
                        end
                    end
                    POLL: begin
                        if (acc_done) begin
                            if (poll_done) begin
                                state_q         <= RESP;
                                cfg_req_valid_o <= 1'b0;
                                cfg_req_addr_o  <= '0;
                                rsp_valid_o     <= 1'b1;
                                rsp_id_o        <= id_q;
                                rsp_err_o       <= 1'b0;
                            end else if (PollGap != 0) begin
                                state_q         <= GAP;
                                gap_cnt_q       <= GapInit;
                                cfg_req_valid_o <= 1'b0;
                                cfg_req_addr_o  <= '0;
                            end
                        end
                    end
                    RESP: begin
                        rsp_valid_o <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/idma_cfg_sequencer.md
Name: idma_cfg_sequencer

Overview:
- Converts one 3D transfer descriptor into the register write/read sequence that programs and launches an iDMA AXI-OBI transfer channel through its frontend register port.
- Sits directly upstream of the channel's cfg_req_i/cfg_rsp_i port and is driven by a core-side command source, such as an Xif offload unit or a command FIFO.
- Returns the transfer ID allocated at launch.
- Optionally waits for the transfer to complete before responding.

Parameters:
- NumDims, 3, dimensions programmed (1..3); stride/reps writes of dimensions above NumDims are skipped.
- PollGap, 4, idle cycles between consecutive DONE_ID reads (0..255).
- OffConf/OffDst/OffSrc/OffLen, 0x00/0x0C/0x10/0x14, frontend register byte offsets.
- OffDstS2/OffSrcS2/OffReps2, 0x18/0x1C/0x20, dimension-2 register offsets.
- OffDstS3/OffSrcS3/OffReps3, 0x24/0x28/0x2C, dimension-3 register offsets.
- OffNextId/OffDoneId, 0x44/0x48, launch and completion ID register offsets.
- idma_fe_reg_req_t, redmule_tile_pkg::idma_fe_reg_req_t, register request type (fields addr, write, wdata, wstrb, valid).
- idma_fe_reg_rsp_t, redmule_tile_pkg::idma_fe_reg_rsp_t, register response type (fields rdata, error, ready).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock domain, reset asynchronous active-low.
- clear_i  in  1  synchronous soft abort.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor ready.
- desc_conf_i  in  32  CONF register value.
- desc_src_i / desc_dst_i / desc_len_i  in  32 each  source address, destination address, length in bytes.
- desc_src_s2_i / desc_dst_s2_i / desc_reps2_i  in  32 each  dimension-2 strides and reps.
- desc_src_s3_i / desc_dst_s3_i / desc_reps3_i  in  32 each  dimension-3 strides and reps.
- desc_wait_i  in  1  1 = respond only after completion.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_id_o  out  32  transfer ID (0 on error).
- rsp_err_o  out  1  register access error.
- cfg_req_o  out  idma_fe_reg_req_t  to channel cfg_req_i.
- cfg_rsp_i  in  idma_fe_reg_rsp_t  from channel cfg_rsp_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: desc_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_err_o=0, cfg_req_o='0, busy_o=0; state=IDLE.
- Descriptor handshake: desc_ready_o=1 only in IDLE. Acceptance (valid&ready) latches all desc_* fields into internal registers.
- Register protocol:
  - An access completes in the cycle where cfg_req_o.valid & cfg_rsp_i.ready.
  - While valid is high, addr/write/wdata/wstrb are held stable until ready.
  - wstrb=4'hF on writes, 4'h0 on reads.
  - rdata and error are sampled in the completing cycle.
- States:
  - IDLE: on acceptance go to WRITE, write index k=0.
  - WRITE: issues writes in the fixed order CONF, DST, SRC, LEN, then DstS2, SrcS2, Reps2 (NumDims≥2), then DstS3, SrcS3, Reps3 (NumDims=3). Count is 4/7/10 writes. k increments on each completion; after the last write go to LAUNCH.
  - LAUNCH: read OffNextId; the read triggers the launch. Latch rdata as id. If desc_wait=0 go to RESP, else go to GAP.
  - GAP: count PollGap cycles with req.valid=0, then go to POLL. PollGap=0 goes directly to POLL.
  - POLL: read OffDoneId. Done when ($signed(rdata - id) >= 0), which is wrap-safe. Go to RESP if done, else back to GAP.
  - RESP: rsp_valid_o=1 with id/err stable until rsp_ready_i, then go to IDLE.
- Error handling: cfg_rsp_i.error=1 on any completing access jumps to RESP with rsp_err_o=1 and rsp_id_o=0. Remaining accesses are not issued.
- Latency, zero-wait bus (ready tied 1), NumDims=3, desc_wait=0:
  - Accept at cycle 0.
  - Writes at cycles 1..10.
  - Launch read at cycle 11.
  - rsp_valid_o at cycle 12.
- Back-to-back descriptors: a new descriptor can only be accepted in IDLE, so the earliest next acceptance is the cycle after the response handshake.
- clear_i:
  - In IDLE, GAP or RESP: go to IDLE next cycle; any pending response is dropped.
  - In WRITE, LAUNCH or POLL with req.valid high: deferred until that access completes, then go to IDLE. No response is produced.
  - Simultaneous clear_i and desc_valid_i in IDLE: clear wins; the descriptor is not accepted.
- Async reset mid-sequence: all state returns to reset values immediately. A partially programmed frontend is not repaired.

Test Plan:
- NumDims=3, zero-wait bus, desc_wait=0, src=0x1000_0000, dst=0x0000_2000, len=0x40, NEXT_ID rdata=5 -> 10 writes to 0x00,0x0C,0x10,0x14,0x18..0x2C with matching wdata, then read 0x44; rsp_id_o=5, rsp_err_o=0, rsp_valid_o at cycle 12.
- desc_wait=1, id=7, DONE_ID returns 5,6,7, PollGap=4 -> three reads of 0x48 spaced by 4 idle cycles; response after the third with rsp_id_o=7.
- Wrap: id=0x0000_0001, DONE_ID returns 0xFFFF_FFFF then 0x0000_0001 -> the first read is not-done, the second is done.
- Random ready stalls of 0-3 cycles on every access -> request fields stable while valid&!ready; same ordering and id as the zero-wait case.
- error=1 on the 3rd write (SRC) -> no further accesses; rsp_err_o=1, rsp_id_o=0.
- clear_i asserted during a stalled write at k=5 -> that write completes, nothing further is issued, no response, desc_ready_o=1 on the following cycle; rsp_ready_i=0 in RESP holds rsp_id_o stable.
